// File: rtl/squash_unit_l2_if.sv
// squash_unit_l2_if -- request/commit/grant bundle for the squash arbiter.
//   arb_val/arb_seq_num/arb_target : per-source squash requests
//   commit_val/commit_seq_num      : commit notification
//   gnt_val/gnt_seq_num/gnt_target : registered squash grant
// master: producer/consumer side (drives requests and commits, sees grants)
// slave : squash_unit_l2 side
interface squash_unit_l2_if #(
  parameter int unsigned p_num_arb      = 2,
  parameter int unsigned p_seq_num_bits = 5,
  parameter int unsigned p_addr_bits    = 32
);
  logic [p_num_arb-1:0]                     arb_val;
  logic [p_num_arb-1:0][p_seq_num_bits-1:0] arb_seq_num;
  logic [p_num_arb-1:0][p_addr_bits-1:0]    arb_target;
  logic                                     commit_val;
  logic [p_seq_num_bits-1:0]                commit_seq_num;
  logic                                     gnt_val;
  logic [p_seq_num_bits-1:0]                gnt_seq_num;
  logic [p_addr_bits-1:0]                   gnt_target;

  modport master (
    output arb_val, arb_seq_num, arb_target, commit_val, commit_seq_num,
    input  gnt_val, gnt_seq_num, gnt_target
  );

  modport slave (
    input  arb_val, arb_seq_num, arb_target, commit_val, commit_seq_num,
    output gnt_val, gnt_seq_num, gnt_target
  );
endinterface

// File: rtl/squash_unit_l2.sv
// squash_unit_l2 -- oldest-first squash arbiter with held-grant filtering.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : squash_unit_l2_if.slave (requests, commit, registered grant)
//   stat_gnt_count / stat_drop_count : saturating counters, present only
//     when SQUASH_UNIT_L2_STATS_EN is defined
// Ages are (seq - head) mod 2^bits against the registered head. The last
// grant stays held until it commits; requests at or younger than it are
// dropped as already squashed or duplicates.
module squash_unit_l2 #(
  parameter int unsigned p_num_arb      = 2,
  parameter int unsigned p_seq_num_bits = 5,
  parameter int unsigned p_addr_bits    = 32
) (
  input  logic clk,
  input  logic rst,
  squash_unit_l2_if.slave bus
`ifdef SQUASH_UNIT_L2_STATS_EN
  ,
  output logic [15:0] stat_gnt_count,
  output logic [15:0] stat_drop_count
`endif
);

  logic [p_seq_num_bits-1:0] head_q, head_d;
  logic                      held_val_q, held_val_d;
  logic [p_seq_num_bits-1:0] held_seq_q, held_seq_d;
  logic                      gnt_val_q, gnt_val_d;
  logic [p_seq_num_bits-1:0] gnt_seq_q, gnt_seq_d;
  logic [p_addr_bits-1:0]    gnt_target_q, gnt_target_d;

  logic                      held_active;
  logic [p_seq_num_bits-1:0] held_age;
  logic [p_seq_num_bits-1:0] age;
  logic                      win_found;
  logic [p_seq_num_bits-1:0] win_age;
  logic [p_seq_num_bits-1:0] win_seq;
  logic [p_addr_bits-1:0]    win_target;
  logic [15:0]               req_count;

  always_comb begin
    // A commit of the held instruction releases it in the same cycle.
    held_active = held_val_q &&
                  !(bus.commit_val && (bus.commit_seq_num == held_seq_q));
    held_age    = held_seq_q - head_q;

    win_found  = 1'b0;
    win_age    = '1;
    win_seq    = '0;
    win_target = '0;
    age        = '0;
    req_count  = '0;
    for (int unsigned i = 0; i < p_num_arb; i++) begin
      age = bus.arb_seq_num[i] - head_q;
      if (bus.arb_val[i]) begin
        req_count = req_count + 16'd1;
        // Strict '<' keeps the lowest index on ties.
        if (!(held_active && (age >= held_age)) &&
            (!win_found || (age < win_age))) begin
          win_found  = 1'b1;
          win_age    = age;
          win_seq    = bus.arb_seq_num[i];
          win_target = bus.arb_target[i];
        end
      end
    end

    head_d       = bus.commit_val ? (bus.commit_seq_num + 1'b1) : head_q;
    gnt_val_d    = win_found;
    gnt_seq_d    = win_found ? win_seq : gnt_seq_q;
    gnt_target_d = win_found ? win_target : gnt_target_q;
    held_val_d   = win_found ? 1'b1 : held_active;
    held_seq_d   = win_found ? win_seq : held_seq_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      held_val_q   <= 1'b0;
      held_seq_q   <= '0;
      gnt_val_q    <= 1'b0;
      gnt_seq_q    <= '0;
      gnt_target_q <= '0;
    end else begin
      head_q       <= head_d;
      held_val_q   <= held_val_d;
      held_seq_q   <= held_seq_d;
      gnt_val_q    <= gnt_val_d;
      gnt_seq_q    <= gnt_seq_d;
      gnt_target_q <= gnt_target_d;
    end
  end

  assign bus.gnt_val     = gnt_val_q;
  assign bus.gnt_seq_num = gnt_seq_q;
  assign bus.gnt_target  = gnt_target_q;

`ifdef SQUASH_UNIT_L2_STATS_EN
  logic [15:0] gnt_cnt_q, gnt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [16:0] gnt_sum, drop_sum;

  always_comb begin
    gnt_sum    = {1'b0, gnt_cnt_q} + {16'd0, win_found};
    drop_sum   = {1'b0, drop_cnt_q} + {1'b0, req_count} - {16'd0, win_found};
    gnt_cnt_d  = gnt_sum[16] ? '1 : gnt_sum[15:0];
    drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      gnt_cnt_q  <= gnt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_gnt_count  = gnt_cnt_q;
  assign stat_drop_count = drop_cnt_q;
`else
  logic unused_req_count;
  assign unused_req_count = ^req_count;
`endif

endmodule
